// File: rtl/sysid_pkg.sv
// Shared types and constants for the system ID boot checker.
package sysid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_ID,
        WAIT_ID,
        ISSUE_TS,
        WAIT_TS,
        COMPARE,
        DONE
    } state_t;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    typedef logic [31:0] sysid_word_t;

endpackage

// File: rtl/sysid_read_sequencer.sv
// Issues one Avalon-MM read and flags the edge at which readdata is valid.
module sysid_read_sequencer
    import sysid_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic launch,
    input  logic launch_addr,
    output logic sysid_address,
    output logic sysid_read,
    output logic sample
);

    localparam logic [3:0] WAIT_LOAD = (READ_LATENCY > 0) ? 4'(READ_LATENCY - 1) : 4'd0;

    logic       waiting;
    logic [3:0] wait_cnt;

    // Zero latency samples in the issue cycle; otherwise when the wait counter expires.
    always_comb begin
        sample = 1'b0;
        if (READ_LATENCY == 0) begin
            sample = sysid_read;
        end else begin
            sample = waiting && (wait_cnt == '0);
        end
    end

    // Read strobe, held address and latency counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sysid_read    <= 1'b0;
            sysid_address <= SYSID_ADDR_ID;
            waiting       <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            sysid_read <= launch;
            if (launch) begin
                sysid_address <= launch_addr;
            end
            if (sysid_read && (READ_LATENCY != 0)) begin
                waiting  <= 1'b1;
                wait_cnt <= WAIT_LOAD;
            end else if (waiting) begin
                if (wait_cnt == '0) begin
                    waiting <= 1'b0;
                end else begin
                    wait_cnt <= wait_cnt - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/sysid_boot_checker.sv
// Reads the sysid ID and timestamp words, compares them, retries, and reports status.
module sysid_boot_checker
    import sysid_pkg::*;
#(
    parameter sysid_word_t EXPECTED_ID        = 32'd0,
    parameter sysid_word_t EXPECTED_TIMESTAMP = 32'd1453208908,
    parameter int unsigned READ_LATENCY       = 1,
    parameter int unsigned MAX_RETRIES        = 2,
    parameter bit          AUTO_START         = 1'b1,
    parameter int unsigned CNT_W              = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    output logic             sysid_address,
    output logic             sysid_read,
    input  sysid_word_t      sysid_readdata,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             id_ok,
    output logic             ts_ok,
    output sysid_word_t      readback_id,
    output sysid_word_t      readback_ts,
    output logic [3:0]       retries_used,
    output logic [CNT_W-1:0] check_count
);

    state_t state, next_state;
    logic   auto_pend;
    logic   launch;
    logic   launch_addr;
    logic   sample;
    logic   start_check;
    logic   match_id;
    logic   match_ts;

    assign match_id = (readback_id == EXPECTED_ID);
    assign match_ts = (readback_ts == EXPECTED_TIMESTAMP);

    sysid_read_sequencer #(
        .READ_LATENCY(READ_LATENCY)
    ) u_seq (
        .clock        (clock),
        .reset_n      (reset_n),
        .launch       (launch),
        .launch_addr  (launch_addr),
        .sysid_address(sysid_address),
        .sysid_read   (sysid_read),
        .sample       (sample)
    );

    // State register; the auto-start request is armed only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            auto_pend <= AUTO_START;
        end else begin
            state     <= next_state;
            auto_pend <= 1'b0;
        end
    end

    // Next-state logic; a read is launched whenever the next state is an issue state.
    always_comb begin
        next_state  = state;
        start_check = 1'b0;
        case (state)
            IDLE: begin
                if (start || auto_pend) begin
                    next_state  = ISSUE_ID;
                    start_check = 1'b1;
                end
            end
            ISSUE_ID, WAIT_ID: next_state = sample ? ISSUE_TS : WAIT_ID;
            ISSUE_TS, WAIT_TS: next_state = sample ? COMPARE : WAIT_TS;
            COMPARE: begin
                if (match_id && match_ts) begin
                    next_state = DONE;
                end else if (retries_used < 4'(MAX_RETRIES)) begin
                    next_state = ISSUE_ID;
                end else begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    next_state  = ISSUE_ID;
                    start_check = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
        launch      = (next_state == ISSUE_ID) || (next_state == ISSUE_TS);
        launch_addr = (next_state == ISSUE_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    end

    // Registered status, readback capture, compare results and counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            id_ok        <= 1'b0;
            ts_ok        <= 1'b0;
            readback_id  <= '0;
            readback_ts  <= '0;
            retries_used <= '0;
            check_count  <= '0;
        end else begin
            busy <= (next_state != IDLE) && (next_state != DONE);
            done <= (next_state == DONE);
            if (start_check) begin
                pass         <= 1'b0;
                retries_used <= '0;
            end
            if (sample && ((state == ISSUE_ID) || (state == WAIT_ID))) begin
                readback_id <= sysid_readdata;
            end
            if (sample && ((state == ISSUE_TS) || (state == WAIT_TS))) begin
                readback_ts <= sysid_readdata;
            end
            if (state == COMPARE) begin
                id_ok <= match_id;
                ts_ok <= match_ts;
                if (next_state == DONE) begin
                    pass <= match_id && match_ts;
                    if (check_count != '1) begin
                        check_count <= check_count + CNT_W'(1);
                    end
                end else begin
                    retries_used <= retries_used + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench: four checker instances (defaults, latency 0, latency 3, no auto-start).
module tb_sysid_boot_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1453208908;
    localparam logic [31:0] BAD_TS = 32'h12345678;

    logic       clk = 1'b0;
    logic [3:0] rst_n_v;
    logic [3:0] start_v;
    logic [3:0] done_v, busy_v, pass_v, read_v;
    int         ts_bad_n = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int unsigned RL = (g == 1) ? 0 : ((g == 2) ? 3 : 1);
        localparam bit          AS = (g == 3) ? 1'b0 : 1'b1;

        logic        sysid_address, sysid_read, busy, done, pass, id_ok, ts_ok;
        logic [31:0] sysid_readdata, readback_id, readback_ts;
        logic [3:0]  retries_used;
        logic [7:0]  check_count;
        logic [15:0] rd_h = '0;
        logic [15:0] ad_h = '0;
        logic [16:0] rv, av;
        logic [15:0] seq = '0;
        int          nreads = 0;
        int          tsr = 0;

        sysid_boot_checker #(
            .EXPECTED_ID       (EXP_ID),
            .EXPECTED_TIMESTAMP(EXP_TS),
            .READ_LATENCY      (RL),
            .MAX_RETRIES       (2),
            .AUTO_START        (AS),
            .CNT_W             (8)
        ) u_dut (
            .clock         (clk),
            .reset_n       (rst_n_v[g]),
            .start         (start_v[g]),
            .sysid_address (sysid_address),
            .sysid_read    (sysid_read),
            .sysid_readdata(sysid_readdata),
            .busy          (busy),
            .done          (done),
            .pass          (pass),
            .id_ok         (id_ok),
            .ts_ok         (ts_ok),
            .readback_id   (readback_id),
            .readback_ts   (readback_ts),
            .retries_used  (retries_used),
            .check_count   (check_count)
        );

        // Slave model: data is valid only exactly RL cycles after the read cycle.
        assign rv = {rd_h, sysid_read};
        assign av = {ad_h, sysid_address};
        assign sysid_readdata = !rv[RL] ? 32'hDEADBEEF :
                                (!av[RL] ? EXP_ID :
                                 ((g == 0 && tsr < ts_bad_n) ? BAD_TS : EXP_TS));

        always @(posedge clk) begin
            rd_h <= {rd_h[14:0], sysid_read};
            ad_h <= {ad_h[14:0], sysid_address};
            if (!rst_n_v[g]) begin
                nreads <= 0;
                tsr    <= 0;
                seq    <= '0;
            end else begin
                if (sysid_read) begin
                    nreads <= nreads + 1;
                    seq    <= {seq[14:0], sysid_address};
                end
                if (rv[RL] && av[RL]) tsr <= tsr + 1;
            end
        end

        assign done_v[g] = done;
        assign busy_v[g] = busy;
        assign pass_v[g] = pass;
        assign read_v[g] = sysid_read;
    end

    task automatic pulse_reset(input int i, input int hold);
        @(negedge clk);
        rst_n_v[i] = 1'b0;
        repeat (hold) @(negedge clk);
        rst_n_v[i] = 1'b1;
    endtask

    // Returns the posedge index (1-based from call) at which done is first seen, or -1.
    task automatic wait_done(input int i, input int lim, output int e);
        e = -1;
        for (int k = 1; k <= lim; k++) begin
            @(posedge clk);
            #1;
            if (done_v[i]) begin
                e = k;
                return;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if ({g_dut[0].sysid_read, g_dut[0].sysid_address, g_dut[0].busy, g_dut[0].done,
             g_dut[0].pass, g_dut[0].id_ok, g_dut[0].ts_ok, g_dut[0].readback_id,
             g_dut[0].readback_ts, g_dut[0].retries_used, g_dut[0].check_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got nonzero outputs, expected all zero");
        end
        n_tests++;
        if (read_v !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_reads: got %b expected 0000", read_v);
        end
    endtask

    task automatic test_default_pass();
        int e;
        ts_bad_n = 0;
        @(negedge clk);
        rst_n_v[0] = 1'b1;
        wait_done(0, 40, e);
        n_tests++;
        if (e !== 6) begin n_fail++; $display("FAIL default_done_edge: got %0d expected 6", e); end
        n_tests++;
        if (pass_v[0] !== 1'b1) begin n_fail++; $display("FAIL default_pass: got %b expected 1", pass_v[0]); end
        n_tests++;
        if (g_dut[0].check_count !== 8'd1) begin
            n_fail++; $display("FAIL default_count: got %0d expected 1", g_dut[0].check_count);
        end
        n_tests++;
        if (g_dut[0].retries_used !== 4'd0) begin
            n_fail++; $display("FAIL default_retries: got %0d expected 0", g_dut[0].retries_used);
        end
        n_tests++;
        if (g_dut[0].nreads !== 2 || g_dut[0].seq[1:0] !== 2'b01) begin
            n_fail++; $display("FAIL default_reads: got %0d reads seq %b expected 2 reads seq 01",
                               g_dut[0].nreads, g_dut[0].seq[1:0]);
        end
        n_tests++;
        if (g_dut[0].readback_ts !== EXP_TS || g_dut[0].id_ok !== 1'b1 || g_dut[0].ts_ok !== 1'b1
            || busy_v[0] !== 1'b0) begin
            n_fail++; $display("FAIL default_status: got ts %h id_ok %b ts_ok %b busy %b expected %h 1 1 0",
                               g_dut[0].readback_ts, g_dut[0].id_ok, g_dut[0].ts_ok, busy_v[0], EXP_TS);
        end
    endtask

    task automatic test_start_busy();
        int e;
        pulse_reset(0, 2);
        repeat (2) @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (busy_v[0] !== 1'b1) begin n_fail++; $display("FAIL busy_edge3: got %b expected 1", busy_v[0]); end
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, 40, e);
        n_tests++;
        if (e + 3 !== 6) begin n_fail++; $display("FAIL busy_start_done_edge: got %0d expected 6", e + 3); end
        @(posedge clk);
        #1;
        n_tests++;
        if (done_v[0] !== 1'b1 || g_dut[0].check_count !== 8'd1) begin
            n_fail++; $display("FAIL busy_start_not_queued: got done %b count %0d expected 1 1",
                               done_v[0], g_dut[0].check_count);
        end
    endtask

    task automatic test_start_in_done();
        int e;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
            n_fail++; $display("FAIL restart_clear: got done %b busy %b expected 0 1", done_v[0], busy_v[0]);
        end
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, 40, e);
        n_tests++;
        if (e !== 5) begin n_fail++; $display("FAIL restart_done_edge: got %0d expected 5", e); end
        n_tests++;
        if (g_dut[0].check_count !== 8'd2 || pass_v[0] !== 1'b1) begin
            n_fail++; $display("FAIL restart_count: got count %0d pass %b expected 2 1",
                               g_dut[0].check_count, pass_v[0]);
        end
    endtask

    task automatic test_retry_fail();
        int e;
        ts_bad_n = 100;
        pulse_reset(0, 2);
        wait_done(0, 60, e);
        n_tests++;
        if (e !== 16) begin n_fail++; $display("FAIL retry_fail_done_edge: got %0d expected 16", e); end
        n_tests++;
        if (pass_v[0] !== 1'b0 || g_dut[0].id_ok !== 1'b1 || g_dut[0].ts_ok !== 1'b0) begin
            n_fail++; $display("FAIL retry_fail_flags: got pass %b id_ok %b ts_ok %b expected 0 1 0",
                               pass_v[0], g_dut[0].id_ok, g_dut[0].ts_ok);
        end
        n_tests++;
        if (g_dut[0].retries_used !== 4'd2 || g_dut[0].readback_ts !== BAD_TS) begin
            n_fail++; $display("FAIL retry_fail_values: got retries %0d ts %h expected 2 %h",
                               g_dut[0].retries_used, g_dut[0].readback_ts, BAD_TS);
        end
        n_tests++;
        if (g_dut[0].nreads !== 6 || g_dut[0].check_count !== 8'd1) begin
            n_fail++; $display("FAIL retry_fail_reads: got %0d reads count %0d expected 6 1",
                               g_dut[0].nreads, g_dut[0].check_count);
        end
    endtask

    task automatic test_retry_once();
        int e;
        ts_bad_n = 1;
        pulse_reset(0, 2);
        wait_done(0, 60, e);
        n_tests++;
        if (e !== 11) begin n_fail++; $display("FAIL retry_once_done_edge: got %0d expected 11", e); end
        n_tests++;
        if (pass_v[0] !== 1'b1 || g_dut[0].retries_used !== 4'd1 || g_dut[0].ts_ok !== 1'b1) begin
            n_fail++; $display("FAIL retry_once_status: got pass %b retries %0d ts_ok %b expected 1 1 1",
                               pass_v[0], g_dut[0].retries_used, g_dut[0].ts_ok);
        end
        n_tests++;
        if (g_dut[0].nreads !== 4) begin
            n_fail++; $display("FAIL retry_once_reads: got %0d expected 4", g_dut[0].nreads);
        end
        ts_bad_n = 0;
    endtask

    task automatic test_latency();
        int e;
        @(negedge clk);
        rst_n_v[1] = 1'b1;
        wait_done(1, 40, e);
        n_tests++;
        if (e !== 4 || pass_v[1] !== 1'b1 || g_dut[1].nreads !== 2) begin
            n_fail++; $display("FAIL latency0: got edge %0d pass %b reads %0d expected 4 1 2",
                               e, pass_v[1], g_dut[1].nreads);
        end
        @(negedge clk);
        rst_n_v[2] = 1'b1;
        wait_done(2, 40, e);
        n_tests++;
        if (e !== 10 || pass_v[2] !== 1'b1 || g_dut[2].nreads !== 2) begin
            n_fail++; $display("FAIL latency3: got edge %0d pass %b reads %0d expected 10 1 2",
                               e, pass_v[2], g_dut[2].nreads);
        end
    endtask

    task automatic test_reset_mid();
        int e;
        int stray;
        pulse_reset(0, 2);
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (busy_v[0] !== 1'b1 || g_dut[0].sysid_address !== 1'b1 || read_v[0] !== 1'b0) begin
            n_fail++; $display("FAIL mid_wait_ts: got busy %b addr %b read %b expected 1 1 0",
                               busy_v[0], g_dut[0].sysid_address, read_v[0]);
        end
        rst_n_v[0] = 1'b0;
        #1;
        n_tests++;
        if ({g_dut[0].sysid_read, g_dut[0].sysid_address, g_dut[0].busy, g_dut[0].done,
             g_dut[0].pass, g_dut[0].id_ok, g_dut[0].ts_ok, g_dut[0].readback_id,
             g_dut[0].readback_ts, g_dut[0].retries_used, g_dut[0].check_count} !== '0) begin
            n_fail++; $display("FAIL mid_async_reset: got busy %b addr %b expected all zero",
                               g_dut[0].busy, g_dut[0].sysid_address);
        end
        stray = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (read_v[0] !== 1'b0) stray++;
        end
        n_tests++;
        if (stray !== 0) begin n_fail++; $display("FAIL mid_reset_reads: got %0d expected 0", stray); end
        @(negedge clk);
        rst_n_v[0] = 1'b1;
        wait_done(0, 40, e);
        n_tests++;
        if (e !== 6 || pass_v[0] !== 1'b1) begin
            n_fail++; $display("FAIL mid_rerun: got edge %0d pass %b expected 6 1", e, pass_v[0]);
        end
    endtask

    task automatic test_no_auto();
        int e;
        @(negedge clk);
        rst_n_v[3] = 1'b1;
        repeat (10) @(negedge clk);
        n_tests++;
        if (g_dut[3].nreads !== 0 || done_v[3] !== 1'b0 || busy_v[3] !== 1'b0) begin
            n_fail++; $display("FAIL noauto_idle: got reads %0d done %b busy %b expected 0 0 0",
                               g_dut[3].nreads, done_v[3], busy_v[3]);
        end
        start_v[3] = 1'b1;
        @(negedge clk);
        start_v[3] = 1'b0;
        wait_done(3, 40, e);
        n_tests++;
        if (e !== 5 || pass_v[3] !== 1'b1) begin
            n_fail++; $display("FAIL noauto_start: got edge %0d pass %b expected 5 1", e, pass_v[3]);
        end
        @(negedge clk);
        start_v[3] = 1'b1;
        @(negedge clk);
        start_v[3] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n_v[3] = 1'b0;
        #1;
        n_tests++;
        if (busy_v[3] !== 1'b0 || done_v[3] !== 1'b0 || g_dut[3].sysid_address !== 1'b0) begin
            n_fail++; $display("FAIL noauto_async_reset: got busy %b done %b addr %b expected 0 0 0",
                               busy_v[3], done_v[3], g_dut[3].sysid_address);
        end
        repeat (2) @(negedge clk);
        rst_n_v[3] = 1'b1;
        repeat (10) @(negedge clk);
        n_tests++;
        if (g_dut[3].nreads !== 0 || busy_v[3] !== 1'b0 || done_v[3] !== 1'b0) begin
            n_fail++; $display("FAIL noauto_stays_idle: got reads %0d busy %b done %b expected 0 0 0",
                               g_dut[3].nreads, busy_v[3], done_v[3]);
        end
    endtask

    initial begin
        rst_n_v = 4'b1111;
        start_v = 4'b0000;
        #1;
        rst_n_v = 4'b0000;
        test_reset();
        test_default_pass();
        test_start_busy();
        test_start_in_done();
        test_retry_fail();
        test_retry_once();
        test_latency();
        test_reset_mid();
        test_no_auto();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
